// File: rtl/sdf_stage_ctrl_if.sv
// sdf_stage_ctrl_if
// Bundles the sample-side handshake and the datapath control outputs of one
// radix-2 SDF FFT stage sequencer.
//   valid_in, sof_in, flush_in       : sample strobe, frame start, drain request
//   dl_valid, bf_sel                 : delay-line shift strobe, butterfly/bypass select
//   tw_en, tw_addr                   : twiddle multiply enable and ROM address
//   valid_out, sof_out               : stage output qualifiers
//   busy, resync_err, in_drop        : status and error pulses
// The master modport is the upstream sample source; the slave modport is the
// sequencer itself.
interface sdf_stage_ctrl_if #(
   parameter int TW_AW = 6
);
   logic             valid_in;
   logic             sof_in;
   logic             flush_in;
   logic             dl_valid;
   logic             bf_sel;
   logic             tw_en;
   logic [TW_AW-1:0] tw_addr;
   logic             valid_out;
   logic             sof_out;
   logic             busy;
   logic             resync_err;
   logic             in_drop;

   modport master (
      output valid_in, sof_in, flush_in,
      input  dl_valid, bf_sel, tw_en, tw_addr, valid_out, sof_out,
             busy, resync_err, in_drop
   );

   modport slave (
      input  valid_in, sof_in, flush_in,
      output dl_valid, bf_sel, tw_en, tw_addr, valid_out, sof_out,
             busy, resync_err, in_drop
   );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl
// Sequencer for one radix-2 single-path delay-feedback FFT stage. Counts
// accepted samples modulo 2*LEN: the first LEN samples of a block fill the
// delay line (and, once primed, push the previous block's differences out
// through the twiddle multiplier); the second LEN samples run the butterfly.
// After the last frame a flush drains the delay line with LEN internal ticks.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : sdf_stage_ctrl_if slave modport (inputs valid_in/sof_in/
//              flush_in, registered control and status outputs)
// Every output is registered, one cycle after the sample or drain tick that
// produced it.
module sdf_stage_ctrl #(
   parameter int LEN   = 8,
   parameter int N_FFT = 64,
   parameter int TW_AW = $clog2(N_FFT)
) (
   input logic             clk,
   input logic             rst,
   sdf_stage_ctrl_if.slave bus
);
   localparam int TW_STRIDE = N_FFT / (2 * LEN);
   localparam int CW        = $clog2(2 * LEN);
   localparam logic [CW-1:0] LAST_FILL  = CW'(LEN - 1);
   localparam logic [CW-1:0] FIRST_BFLY = CW'(LEN);
   localparam logic [CW-1:0] LAST_BFLY  = CW'(2 * LEN - 1);

   typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             primed_q, primed_d;
   logic             flush_pend_q, flush_pend_d;
   logic             dl_valid_q, dl_valid_d;
   logic             bf_sel_q, bf_sel_d;
   logic             tw_en_q, tw_en_d;
   logic [TW_AW-1:0] tw_addr_q, tw_addr_d;
   logic             valid_out_q, valid_out_d;
   logic             sof_out_q, sof_out_d;
   logic             busy_q, busy_d;
   logic             resync_err_q, resync_err_d;
   logic             in_drop_q, in_drop_d;

   // Next-state and output decode. Outputs default to 0 so gap cycles emit
   // nothing; counter and flags hold unless a sample or drain tick is taken.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      primed_d     = primed_q;
      flush_pend_d = flush_pend_q;
      dl_valid_d   = 1'b0;
      bf_sel_d     = 1'b0;
      tw_en_d      = 1'b0;
      tw_addr_d    = '0;
      valid_out_d  = 1'b0;
      sof_out_d    = 1'b0;
      resync_err_d = 1'b0;
      in_drop_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // Only a frame start wakes the stage; it is the cnt=0 fill sample.
            if (bus.valid_in && bus.sof_in) begin
               state_d    = FILL;
               cnt_d      = CW'(1);
               primed_d   = 1'b0;
               dl_valid_d = 1'b1;
            end
         end

         FILL, BFLY: begin
            // A flush at a block boundary is either acted on at once (primed)
            // or meaningless (nothing stored yet), so it is only remembered
            // when it arrives mid-block.
            if (bus.flush_in && (cnt_q != '0)) begin
               flush_pend_d = 1'b1;
            end

            if ((state_q == FILL) && (cnt_q == '0) && primed_q &&
                (bus.flush_in || flush_pend_q)) begin
               state_d   = DRAIN;
               in_drop_d = bus.valid_in;
            end else if (bus.valid_in) begin
               dl_valid_d = 1'b1;
               if (bus.sof_in && (cnt_q != '0)) begin
                  // Frame start mid-block: abandon the block and restart
                  // unprimed with this sample as cnt=0.
                  resync_err_d = 1'b1;
                  primed_d     = 1'b0;
                  state_d      = FILL;
                  cnt_d        = CW'(1);
               end else if (state_q == FILL) begin
                  if (primed_q) begin
                     valid_out_d = 1'b1;
                     tw_en_d     = 1'b1;
                     tw_addr_d   = TW_AW'(cnt_q) * TW_AW'(TW_STRIDE);
                  end
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q == LAST_FILL) begin
                     state_d = BFLY;
                  end
               end else begin
                  bf_sel_d    = 1'b1;
                  valid_out_d = 1'b1;
                  sof_out_d   = !primed_q && (cnt_q == FIRST_BFLY);
                  if (cnt_q == LAST_BFLY) begin
                     cnt_d    = '0;
                     primed_d = 1'b1;
                     state_d  = (flush_pend_q || bus.flush_in) ? DRAIN : FILL;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
         end

         DRAIN: begin
            // Self-timed: one tick per clock pushes the last differences out.
            dl_valid_d  = 1'b1;
            valid_out_d = 1'b1;
            tw_en_d     = 1'b1;
            tw_addr_d   = TW_AW'(cnt_q) * TW_AW'(TW_STRIDE);
            in_drop_d   = bus.valid_in;
            if (cnt_q == LAST_FILL) begin
               state_d      = IDLE;
               cnt_d        = '0;
               primed_d     = 1'b0;
               flush_pend_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset drops any partial block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         primed_q     <= 1'b0;
         flush_pend_q <= 1'b0;
         dl_valid_q   <= 1'b0;
         bf_sel_q     <= 1'b0;
         tw_en_q      <= 1'b0;
         tw_addr_q    <= '0;
         valid_out_q  <= 1'b0;
         sof_out_q    <= 1'b0;
         busy_q       <= 1'b0;
         resync_err_q <= 1'b0;
         in_drop_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         primed_q     <= primed_d;
         flush_pend_q <= flush_pend_d;
         dl_valid_q   <= dl_valid_d;
         bf_sel_q     <= bf_sel_d;
         tw_en_q      <= tw_en_d;
         tw_addr_q    <= tw_addr_d;
         valid_out_q  <= valid_out_d;
         sof_out_q    <= sof_out_d;
         busy_q       <= busy_d;
         resync_err_q <= resync_err_d;
         in_drop_q    <= in_drop_d;
      end
   end

   assign bus.dl_valid   = dl_valid_q;
   assign bus.bf_sel     = bf_sel_q;
   assign bus.tw_en      = tw_en_q;
   assign bus.tw_addr    = tw_addr_q;
   assign bus.valid_out  = valid_out_q;
   assign bus.sof_out    = sof_out_q;
   assign bus.busy       = busy_q;
   assign bus.resync_err = resync_err_q;
   assign bus.in_drop    = in_drop_q;
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl
// Drives sdf_stage_ctrl (LEN=4, N_FFT=16, twiddle stride 2) with directed
// sample sequences. Each stimulus that should produce output pushes its
// expected output vector into a queue; a monitor pops and compares whenever
// any output qualifier is active, and flags outputs nobody asked for.
module tb_sdf_stage_ctrl;
   typedef struct packed {
      logic       dl;
      logic       bf;
      logic       twen;
      logic [3:0] addr;
      logic       vo;
      logic       sofo;
      logic       rerr;
      logic       drop;
   } exp_t;

   logic clk;
   logic rst;
   int   checkCount;
   int   passCount;
   exp_t sbQ[$];

   sdf_stage_ctrl_if #(.TW_AW(4)) bus ();

   sdf_stage_ctrl #(.LEN(4), .N_FFT(16), .TW_AW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(bit dl, bit bf, bit twen, int addr, bit vo,
                               bit sofo, bit rerr, bit drop);
      exp_t e;
      e.dl   = dl;
      e.bf   = bf;
      e.twen = twen;
      e.addr = 4'(addr);
      e.vo   = vo;
      e.sofo = sofo;
      e.rerr = rerr;
      e.drop = drop;
      return e;
   endfunction

   function automatic exp_t sampleDut();
      exp_t a;
      a.dl   = bus.dl_valid;
      a.bf   = bus.bf_sel;
      a.twen = bus.tw_en;
      a.addr = bus.tw_addr;
      a.vo   = bus.valid_out;
      a.sofo = bus.sof_out;
      a.rerr = bus.resync_err;
      a.drop = bus.in_drop;
      return a;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
   endtask

   task automatic applyStimulus(input bit v, input bit s, input bit f);
      @(negedge clk);
      bus.valid_in = v;
      bus.sof_in   = s;
      bus.flush_in = f;
   endtask

   // One 8-sample block starting at startK; gap idle cycles follow each sample.
   task automatic runBlock(input bit withSof, input bit primed, input int gap,
                           input int flushAt, input int startK);
      for (int k = startK; k < 8; k++) begin
         applyStimulus(1'b1, withSof && (k == startK), k == flushAt);
         if (k < 4) begin
            if (primed) sbQ.push_back(mk(1, 0, 1, 2 * k, 1, 0, 0, 0));
            else        sbQ.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
         end else begin
            sbQ.push_back(mk(1, 1, 0, 0, 1, !primed && (k == 4), 0, 0));
         end
         for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (g == 0 && k == startK) checkOutput("busy_gap", 32'(bus.busy), 32'd1);
         end
      end
   endtask

   task automatic expectDrain(input int dropAt);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(k == dropAt, 1'b0, 1'b0);
         sbQ.push_back(mk(1, 0, 1, 2 * k, 1, 0, 0, k == dropAt));
      end
   endtask

   // Monitor: any active qualifier must match the oldest expected vector.
   initial begin
      exp_t act;
      exp_t exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            act = sampleDut();
            if (act != '0) begin
               if (sbQ.size() == 0) begin
                  checkOutput("unexpected_output", 32'(act), 32'd0);
               end else begin
                  exp = sbQ.pop_front();
                  checkOutput("stage_output", 32'(act), 32'(exp));
               end
            end
         end
      end
   end

   initial begin
      checkCount   = 0;
      passCount    = 0;
      rst          = 1'b1;
      bus.valid_in = 1'b0;
      bus.sof_in   = 1'b0;
      bus.flush_in = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_outputs", 32'(sampleDut()), 32'd0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;

      // Partial frame into BFLY cnt=6, then asynchronous reset.
      applyStimulus(1'b1, 1'b1, 1'b0);
      sbQ.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 1; k < 6; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         if (k < 4) sbQ.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
         else       sbQ.push_back(mk(1, 1, 0, 0, 1, k == 4, 0, 0));
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("busy_in_bfly", 32'(bus.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("midblock_reset_outputs", 32'(sampleDut()), 32'd0);
      checkOutput("midblock_reset_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // valid_in without sof_in stays idle and silent.
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_ignores_valid", 32'(bus.busy), 32'd0);

      // Unprimed frame, primed block, primed block with gaps, flush at cnt=5.
      runBlock(1'b1, 1'b0, 0, -1, 0);
      runBlock(1'b0, 1'b1, 0, -1, 0);
      runBlock(1'b0, 1'b1, 3, -1, 0);
      runBlock(1'b0, 1'b1, 0, 5, 0);
      expectDrain(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_after_drain", 32'(bus.busy), 32'd0);

      // New frame, resync at cnt=3, then finish the restarted unprimed block.
      applyStimulus(1'b1, 1'b1, 1'b0);
      sbQ.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 1; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         sbQ.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      sbQ.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
      runBlock(1'b0, 1'b0, 0, -1, 1);

      // Flush at a primed block boundary drains immediately.
      applyStimulus(1'b0, 1'b0, 1'b1);
      expectDrain(-1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_after_boundary_flush", 32'(bus.busy), 32'd0);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
